// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI master (mode 0, MSB first, 8-bit) that lives in the 68k IIC/SPI
// register window. Holds the CPU-visible register file, the SCLK divider
// and the byte-shift sequencer, and generates DTACK_L and the interrupt.
//
// Ports
//   Clk       system clock
//   Reset_H   asynchronous active-high reset
//   Enable_H  window select, high for the whole bus cycle
//   Address   CPU A[3:1] register select
//   WE_L      CPU R/W, low = write
//   DataIn    CPU write data
//   DataOut   registered read data, 0 while not selected
//   DTACK_L   data acknowledge to the CPU
//   IRQ_L     transfer-complete interrupt, active low
//   SCLK      SPI clock
//   MOSI      SPI data out
//   MISO      SPI data in, sampled as SCLK rises
//   SS_L      active-low slave selects
module spi_master_ctrl #(
    parameter logic [7:0] DIV_RESET = 8'd24,
    parameter int         NUM_SS    = 8
) (
    input  logic              Clk,
    input  logic              Reset_H,
    input  logic              Enable_H,
    input  logic [2:0]        Address,
    input  logic              WE_L,
    input  logic [7:0]        DataIn,
    output logic [7:0]        DataOut,
    output logic              DTACK_L,
    output logic              IRQ_L,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_L
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } SpiState;

    SpiState     state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bitCnt_q, bitCnt_d;
    logic [7:0]  shiftReg_q, shiftReg_d;
    logic        sclk_q, sclk_d;
    logic        misoBit_q, misoBit_d;
    logic        ie_q, ie_d;
    logic        en_q, en_d;
    logic        spif_q, spif_d;
    logic        wcol_q, wcol_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  ssReg_q, ssReg_d;
    logic [7:0]  dataOut_q, dataOut_d;
    logic        dtackL_q, dtackL_d;
    logic        irqL_q, irqL_d;
    logic        enPrev_q;

    logic        access;
    logic        busy;
    logic [7:0]  readData;

    // An access is the first clock of a bus cycle; holding Enable_H longer
    // must not repeat the register action.
    assign access = Enable_H & ~enPrev_q;
    assign busy   = (state_q != IDLE);

    // Read multiplexer, captured into DataOut on the access clock.
    always_comb begin
        readData = 8'h00;
        case (Address)
            3'd0:    readData = {ie_q, en_q, 6'b000000};
            3'd1:    readData = {spif_q, wcol_q, 5'b00000, busy};
            3'd2:    readData = data_q;
            3'd3:    readData = div_q;
            3'd4:    readData = ssReg_q;
            default: readData = 8'h00;
        endcase
    end

    // Next-state logic: bus register actions first, then the sequencer, so
    // that a SPIF set from DONE overrides a clear from the same clock.
    // MISO is parked in misoBit_q at the rising SCLK and only shifted in at
    // the falling edge, because the LSB still holds a TX bit until then.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        sclk_d     = sclk_q;
        misoBit_d  = misoBit_q;
        ie_d       = ie_q;
        en_d       = en_q;
        spif_d     = spif_q;
        wcol_d     = wcol_q;
        data_d     = data_q;
        div_d      = div_q;
        ssReg_d    = ssReg_q;
        dataOut_d  = dataOut_q;
        dtackL_d   = ~(Enable_H & enPrev_q);
        irqL_d     = ~(ie_q & spif_q);

        if (!Enable_H) begin
            dataOut_d = 8'h00;
        end else if (access) begin
            dataOut_d = readData;
        end

        if (access && !WE_L) begin
            case (Address)
                3'd0: begin
                    ie_d = DataIn[7];
                    en_d = DataIn[6];
                end
                3'd1: begin
                    if (DataIn[7]) spif_d = 1'b0;
                    if (DataIn[6]) wcol_d = 1'b0;
                end
                3'd2: begin
                    if (busy) begin
                        wcol_d = 1'b1;
                    end else if (en_q) begin
                        shiftReg_d = DataIn;
                        cnt_d      = div_q;
                        bitCnt_d   = 3'd0;
                        sclk_d     = 1'b0;
                        state_d    = SHIFT_LO;
                    end else begin
                        data_d = DataIn;
                    end
                end
                3'd3:    div_d   = DataIn;
                3'd4:    ssReg_d = DataIn;
                default: ;
            endcase
        end else if (access && WE_L && Address == 3'd2) begin
            spif_d = 1'b0;
        end

        if (busy && !en_q) begin
            state_d = IDLE;
            sclk_d  = 1'b0;
        end else begin
            case (state_q)
                SHIFT_LO: begin
                    if (cnt_q == 8'd0) begin
                        state_d   = SHIFT_HI;
                        sclk_d    = 1'b1;
                        misoBit_d = MISO;
                        cnt_d     = div_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt_q == 8'd0) begin
                        sclk_d = 1'b0;
                        if (bitCnt_q == 3'd7) begin
                            state_d = DONE;
                            data_d  = {shiftReg_q[6:0], misoBit_q};
                        end else begin
                            state_d    = SHIFT_LO;
                            shiftReg_d = {shiftReg_q[6:0], misoBit_q};
                            bitCnt_d   = bitCnt_q + 3'd1;
                            cnt_d      = div_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    spif_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and register file.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bitCnt_q   <= 3'd0;
            shiftReg_q <= 8'h00;
            sclk_q     <= 1'b0;
            misoBit_q  <= 1'b0;
            ie_q       <= 1'b0;
            en_q       <= 1'b0;
            spif_q     <= 1'b0;
            wcol_q     <= 1'b0;
            data_q     <= 8'h00;
            div_q      <= DIV_RESET;
            ssReg_q    <= 8'h00;
            dataOut_q  <= 8'h00;
            dtackL_q   <= 1'b1;
            irqL_q     <= 1'b1;
            enPrev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            sclk_q     <= sclk_d;
            misoBit_q  <= misoBit_d;
            ie_q       <= ie_d;
            en_q       <= en_d;
            spif_q     <= spif_d;
            wcol_q     <= wcol_d;
            data_q     <= data_d;
            div_q      <= div_d;
            ssReg_q    <= ssReg_d;
            dataOut_q  <= dataOut_d;
            dtackL_q   <= dtackL_d;
            irqL_q     <= irqL_d;
            enPrev_q   <= Enable_H;
        end
    end

    // MOSI is simply the top of the shift register, so it holds its last
    // bit after DONE or an abort.
    assign DataOut = dataOut_q;
    assign DTACK_L = dtackL_q;
    assign IRQ_L   = irqL_q;
    assign SCLK    = sclk_q;
    assign MOSI    = shiftReg_q[7];
    assign SS_L    = ~ssReg_q[NUM_SS-1:0];

endmodule
